// File: rtl/uart_tx_unit.sv
// UART transmitter: start bit, DBITS data bits LSB first, optional parity,
// stop bit of SB_TICK sample ticks. Bit timing from a 16x oversampling tick.
module uart_tx_unit #(
    parameter int DBITS      = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic             tx_start,
    input  logic [DBITS-1:0] data_in,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int             BW        = (DBITS > 1) ? $clog2(DBITS) : 1;
    localparam logic [BW-1:0]  LAST_BIT  = BW'(DBITS - 1);
    localparam logic [4:0]     LAST_STOP = 5'(SB_TICK - 1);
    localparam logic [4:0]     LAST_TICK = 5'd15;
    localparam logic           ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [4:0]       tick_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [DBITS-1:0] shreg;
    logic             par_bit;

    // Frame sequencer; tx/tx_busy/tx_done are all registered here so the
    // line never sees a combinational path from the request side.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        // Start bit goes out on the accepting edge; its length
                        // is counted from the next sample tick onward.
                        shreg    <= data_in;
                        par_bit  <= (^data_in) ^ ODD;
                        tick_cnt <= '0;
                        state    <= START;
                        tx_busy  <= 1'b1;
                        tx       <= 1'b0;
                    end
                end
                START: begin
                    if (sample_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= DATA;
                            tx       <= shreg[0];
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (sample_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            shreg    <= shreg >> 1;
                            if (bit_cnt == LAST_BIT) begin
                                if (PARITY_EN != 0) begin
                                    state <= PARITY;
                                    tx    <= par_bit;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx      <= shreg[1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_tick) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (sample_tick) begin
                        if (tick_cnt == LAST_STOP) begin
                            // Back in IDLE while tx_done is high, so a new
                            // request in that cycle starts with no idle gap.
                            tick_cnt <= '0;
                            state    <= IDLE;
                            tx_busy  <= 1'b0;
                            tx_done  <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
